// File: rtl/qspi_frame_tx.sv
// QSPI mode-0 frame transmitter: one nibble per SCLK, MSB nibble first, with gated SCLK and abort.
// Optional QSPI_TX_SEQ_HDR_EN prefixes each frame with the 8-bit frame_count as two header nibbles.
module qspi_frame_tx #(
  parameter int CLK_DIV     = 32,
  parameter int PKT_NIBBLES = 8,
  parameter int SETUP_HALF  = 1,
  parameter int HOLD_HALF   = 6,
  parameter int GAP_HALF    = 100
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4*PKT_NIBBLES-1:0] pkt_data,
  input  logic                     pkt_valid,
  output logic                     pkt_ready,
  input  logic                     abort,
  output logic                     qspi_cs,
  output logic                     qspi_clk,
  output logic [3:0]               qspi_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic [7:0]               frame_count,
  output logic [2:0]               state_dbg
);

  // Handshake: a payload transfers on a rising clk edge where pkt_valid and pkt_ready are both 1.
  // pkt_ready is registered, so it rises one cycle after IDLE is entered and drops on acceptance.
`ifdef QSPI_TX_SEQ_HDR_EN
  localparam int N = PKT_NIBBLES + 2;
`else
  localparam int N = PKT_NIBBLES;
`endif
  localparam int W  = 4 * N;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int NW = $clog2(N + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [15:0]   ph_cnt;
  logic [NW-1:0] nib_cnt;
  logic [W-1:0]  sr;
  logic [W-1:0]  sr_next;
  logic [W-1:0]  frame_word;
  logic          tick;
  logic          in_frame;

`ifdef QSPI_TX_SEQ_HDR_EN
  assign frame_word = {frame_count, pkt_data};
`else
  assign frame_word = pkt_data;
`endif

  assign tick      = (div_cnt == DW'(CLK_DIV - 1));
  assign sr_next   = sr << 4;
  assign in_frame  = (state == SETUP) || (state == SHIFT) || (state == HOLD);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      ph_cnt      <= '0;
      nib_cnt     <= '0;
      sr          <= '0;
      pkt_ready   <= 1'b0;
      qspi_cs     <= 1'b1;
      qspi_clk    <= 1'b0;
      qspi_data   <= 4'h0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 8'h00;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + 1'b1;

      if (abort && in_frame) begin
        state     <= GAP;
        div_cnt   <= '0;
        ph_cnt    <= '0;
        qspi_cs   <= 1'b1;
        qspi_clk  <= 1'b0;
        qspi_data <= 4'h0;
        busy      <= 1'b1;
        pkt_ready <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
            // An abort coinciding with a pending acceptance holds the payload off.
            if (pkt_ready && pkt_valid && !abort) begin
              sr        <= frame_word;
              qspi_data <= frame_word[W-1 -: 4];
              qspi_cs   <= 1'b0;
              pkt_ready <= 1'b0;
              busy      <= 1'b1;
              ph_cnt    <= '0;
              nib_cnt   <= '0;
              state     <= SETUP;
            end else begin
              pkt_ready <= 1'b1;
            end
          end
          SETUP: if (tick) begin
            if (ph_cnt == 16'(SETUP_HALF - 1)) begin
              ph_cnt <= '0;
              state  <= SHIFT;
            end else begin
              ph_cnt <= ph_cnt + 16'd1;
            end
          end
          SHIFT: if (tick) begin
            qspi_clk <= ~qspi_clk;
            if (!qspi_clk) begin
              nib_cnt <= nib_cnt + 1'b1;
            end else if (nib_cnt == NW'(N)) begin
              ph_cnt <= '0;
              state  <= HOLD;
            end else begin
              sr        <= sr_next;
              qspi_data <= sr_next[W-1 -: 4];
            end
          end
          HOLD: if (tick) begin
            if (ph_cnt == 16'(HOLD_HALF - 1)) begin
              qspi_cs     <= 1'b1;
              qspi_data   <= 4'h0;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 8'd1;
              ph_cnt      <= '0;
              state       <= GAP;
            end else begin
              ph_cnt <= ph_cnt + 16'd1;
            end
          end
          GAP: if (tick) begin
            if (ph_cnt == 16'(GAP_HALF - 1)) begin
              ph_cnt <= '0;
              busy   <= 1'b0;
              state  <= IDLE;
            end else begin
              ph_cnt <= ph_cnt + 16'd1;
            end
          end
          default: begin
            state     <= IDLE;
            div_cnt   <= '0;
            ph_cnt    <= '0;
            qspi_cs   <= 1'b1;
            qspi_clk  <= 1'b0;
            qspi_data <= 4'h0;
            busy      <= 1'b0;
            pkt_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
